// File: rtl/md_pkg.sv
// Shared types and function codes for the mult/div issue controller.
package md_pkg;

  typedef enum logic [3:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MTHI  = 4'd5,
    MTLO  = 4'd6,
    MFHI  = 4'd7,
    MFLO  = 4'd8
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  localparam logic [2:0] MD_F_NOP  = 3'd0;
  localparam logic [2:0] MD_F_WHI  = 3'd1;
  localparam logic [2:0] MD_F_WLO  = 3'd2;
  localparam logic [2:0] MD_F_MULT = 3'd3;
  localparam logic [2:0] MD_F_DIV  = 3'd4;

endpackage

// File: rtl/md_issue_ctrl.sv
// Issues mult/div/HI-LO operations from EX to the mult/div unit and stalls
// EX for the fixed latency of each multi-cycle operation.
module md_issue_ctrl
  import md_pkg::*;
#(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        ex_flush,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [2:0]  md_f,
  output logic        md_sign,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        ex_stall,
  output logic [31:0] mf_result,
  output logic        div_zero,
  output logic        busy
);

  localparam logic [5:0] MUL_CNT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_CNT = 6'(DIV_LAT - 1);

  md_state_t  state, state_nxt;
  logic [5:0] cnt, cnt_nxt;
  md_op_t     op;

  assign op   = md_op_t'(ex_op);
  assign md_a = ex_rs;
  assign md_b = ex_rt;
  assign busy = (state == BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Outputs are gated by rst so they are quiet for the whole reset window,
  // not just after the state register has cleared.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    md_f      = MD_F_NOP;
    md_sign   = 1'b0;
    ex_stall  = 1'b0;
    div_zero  = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (ex_valid && !ex_flush) begin
            case (op)
              MULT, MULTU: begin
                md_f      = MD_F_MULT;
                md_sign   = (op == MULT);
                ex_stall  = 1'b1;
                state_nxt = BUSY;
                cnt_nxt   = MUL_CNT;
              end
              DIV, DIVU: begin
                if (ex_rt != '0) begin
                  md_f      = MD_F_DIV;
                  md_sign   = (op == DIV);
                  ex_stall  = 1'b1;
                  state_nxt = BUSY;
                  cnt_nxt   = DIV_CNT;
                end else begin
                  div_zero = 1'b1;
                end
              end
              MTHI:    md_f = MD_F_WHI;
              MTLO:    md_f = MD_F_WLO;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (ex_flush) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else if (cnt != '0) begin
            ex_stall = 1'b1;
            cnt_nxt  = cnt - 6'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    mf_result = '0;
    if (!rst && ex_valid) begin
      if (op == MFHI)
        mf_result = md_hi;
      else if (op == MFLO)
        mf_result = md_lo;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Scoreboard bench for md_issue_ctrl with a behavioural HI/LO unit.
module tb_md_issue_ctrl;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic [3:0]  ex_op = 4'd0;
  logic [31:0] ex_rs = '0;
  logic [31:0] ex_rt = '0;
  logic        ex_flush = 1'b0;
  logic [31:0] md_hi, md_lo;
  logic [2:0]  md_f;
  logic        md_sign, ex_stall, div_zero, busy;
  logic [31:0] md_a, md_b, mf_result;

  md_issue_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_flush(ex_flush),
    .md_hi(md_hi), .md_lo(md_lo), .md_f(md_f), .md_sign(md_sign),
    .md_a(md_a), .md_b(md_b), .ex_stall(ex_stall), .mf_result(mf_result),
    .div_zero(div_zero), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural mult/div unit: HI/LO update on the edge that sees md_f.
  logic [31:0] hi_r = '0, lo_r = '0;
  logic [63:0] prod;
  int          sa, sd;
  assign md_hi = hi_r;
  assign md_lo = lo_r;

  always @(posedge clk) begin
    case (md_f)
      3'd1: hi_r <= md_a;
      3'd2: lo_r <= md_a;
      3'd3: begin
        if (md_sign) prod = {{32{md_a[31]}}, md_a} * {{32{md_b[31]}}, md_b};
        else         prod = {32'd0, md_a} * {32'd0, md_b};
        hi_r <= prod[63:32];
        lo_r <= prod[31:0];
      end
      3'd4: begin
        if (md_b != 32'd0) begin
          if (md_sign) begin
            if (md_a == 32'h8000_0000 && md_b == 32'hFFFF_FFFF) begin
              lo_r <= 32'h8000_0000;
              hi_r <= 32'd0;
            end else begin
              sa = md_a;
              sd = md_b;
              lo_r <= 32'(sa / sd);
              hi_r <= 32'(sa % sd);
            end
          end else begin
            lo_r <= md_a / md_b;
            hi_r <= md_a % md_b;
          end
        end
      end
      default: ;
    endcase
  end

  typedef struct {
    int          id;
    logic [2:0]  f;
    logic        sign;
    logic        stall;
    logic        dz;
    logic        bsy;
    logic [31:0] mf;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t scb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   vec_id = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL vec %0d %s: got %h expected %h", id, nm, act, exp);
      miscompares++;
    end
  endtask

  always @(negedge clk) begin
    if (scb.size() > 0) begin
      exp_t e;
      e = scb.pop_front();
      vectors++;
      chk(e.id, "md_f",      32'(md_f),     32'(e.f));
      chk(e.id, "md_sign",   32'(md_sign),  32'(e.sign));
      chk(e.id, "ex_stall",  32'(ex_stall), 32'(e.stall));
      chk(e.id, "div_zero",  32'(div_zero), 32'(e.dz));
      chk(e.id, "busy",      32'(busy),     32'(e.bsy));
      chk(e.id, "mf_result", mf_result,     e.mf);
      chk(e.id, "md_a",      md_a,          e.a);
      chk(e.id, "md_b",      md_b,          e.b);
    end
  end

  task automatic step(input logic r, input logic v, input logic [3:0] op,
                      input logic [31:0] rs, input logic [31:0] rt, input logic fl,
                      input logic [2:0] f, input logic sg, input logic st,
                      input logic [31:0] mf, input logic dz, input logic bz);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ex_valid = v; ex_op = op; ex_rs = rs; ex_rt = rt; ex_flush = fl;
    vec_id++;
    e = '{vec_id, f, sg, st, dz, bz, mf, rs, rt};
    scb.push_back(e);
  endtask

  initial begin
    // reset holds every output low even with a valid MULT presented
    step(1, 1, MULT, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 0, 0, 32'd0, 0, 0);
    step(0, 0, NOP, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd0, 0, 0);

    // MULT -2 * 3: four stall cycles, four busy cycles
    step(0, 1, MULT, 32'hFFFF_FFFE, 32'd3, 0, 3'd3, 1, 1, 32'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, MULT, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 0, 1, 32'd0, 0, 1);
    step(0, 1, MULT, 32'hFFFF_FFFE, 32'd3, 0, 3'd0, 0, 0, 32'd0, 0, 1);
    step(0, 1, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'hFFFF_FFFA, 0, 0);

    // DIVU 100 / 7: 32 stall cycles
    step(0, 1, DIVU, 32'd100, 32'd7, 0, 3'd4, 0, 1, 32'd0, 0, 0);
    for (int i = 1; i <= 32; i++)
      step(0, 1, DIVU, 32'd100, 32'd7, 0, 3'd0, 0, (i < 32), 32'd0, 0, 1);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd14, 0, 0);
    step(0, 1, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd2, 0, 0);

    // divide by zero is suppressed, HI/LO untouched
    step(0, 1, DIV, 32'd5, 32'd0, 0, 3'd0, 0, 0, 32'd0, 1, 0);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd14, 0, 0);
    step(0, 1, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd2, 0, 0);

    // MTHI/MTLO then read back
    step(0, 1, MTHI, 32'h1234_5678, 32'd0, 0, 3'd1, 0, 0, 32'd0, 0, 0);
    step(0, 1, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'h1234_5678, 0, 0);
    step(0, 1, MTLO, 32'h0000_ABCD, 32'd0, 0, 3'd2, 0, 0, 32'd0, 0, 0);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'h0000_ABCD, 0, 0);
    step(0, 0, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd0, 0, 0);

    // flush in the accept cycle
    step(0, 1, MULT, 32'd5, 32'd6, 1, 3'd0, 0, 0, 32'd0, 0, 0);
    step(0, 0, NOP, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd0, 0, 0);

    // signed overflow divide issues like any other
    step(0, 1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd4, 1, 1, 32'd0, 0, 0);
    for (int i = 1; i <= 32; i++)
      step(0, 1, DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 0, (i < 32), 32'd0, 0, 1);

    // DIV -7 / 2 flushed in its 5th stall cycle, then MULTU
    step(0, 1, DIV, 32'hFFFF_FFF9, 32'd2, 0, 3'd4, 1, 1, 32'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, DIV, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 0, 1, 32'd0, 0, 1);
    step(0, 1, DIV, 32'hFFFF_FFF9, 32'd2, 1, 3'd0, 0, 0, 32'd0, 0, 1);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'hFFFF_FFFD, 0, 0);
    step(0, 1, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'hFFFF_FFFF, 0, 0);
    step(0, 1, MULTU, 32'hFFFF_FFFF, 32'd2, 0, 3'd3, 0, 1, 32'd0, 0, 0);
    for (int i = 0; i < 3; i++)
      step(0, 1, MULTU, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 0, 1, 32'd0, 0, 1);
    step(0, 1, MULTU, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 0, 0, 32'd0, 0, 1);
    step(0, 1, MFHI, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd1, 0, 0);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'hFFFF_FFFE, 0, 0);

    // reset mid-BUSY: outputs drop between clock edges, nothing issues after release
    step(0, 1, DIV, 32'd100, 32'd7, 0, 3'd4, 1, 1, 32'd0, 0, 0);
    for (int i = 2; i <= 9; i++)
      step(0, 1, DIV, 32'd100, 32'd7, 0, 3'd0, 0, 1, 32'd0, 0, 1);
    step(1, 1, DIV, 32'd100, 32'd7, 0, 3'd0, 0, 0, 32'd0, 0, 0);
    step(1, 0, NOP, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd0, 0, 0);
    step(0, 0, NOP, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd0, 0, 0);
    step(0, 0, NOP, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd0, 0, 0);
    step(0, 1, MFLO, 32'd0, 32'd0, 0, 3'd0, 0, 0, 32'd14, 0, 0);

    for (int k = 0; k < 4 && scb.size() > 0; k++)
      @(negedge clk);
    #1;
    if (scb.size() > 0) begin
      $display("FAIL drain: got %0d pending expected 0", scb.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: EX stall cycles for MULT/MULTU, including the accept cycle; legal range 1..63.
REQ-002 Parameter DIV_LAT, default 32: EX stall cycles for DIV/DIVU, including the accept cycle; legal range 1..63.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ex_valid  in  1  EX stage holds a valid instruction.
REQ-006 ex_op  in  4  md_op_t operation code of the EX instruction.
REQ-007 ex_rs  in  32  first operand (dividend, multiplicand, or MTHI/MTLO source).
REQ-008 ex_rt  in  32  second operand (divisor, multiplier).
REQ-009 ex_flush  in  1  EX instruction is squashed this cycle.
REQ-010 md_hi / md_lo  in  32 each  current HI/LO from the mult/div unit.
REQ-011 md_f  out  3  function code to the mult/div unit: 0 nop, 1 write HI, 2 write LO, 3 mult, 4 div.
REQ-012 md_sign  out  1  signed-operation select to the mult/div unit.
REQ-013 md_a / md_b  out  32 each  operand buses to the mult/div unit.
REQ-014 ex_stall  out  1  holds the EX stage and all earlier stages.
REQ-015 mf_result  out  32  MFHI/MFLO result to the EX writeback mux.
REQ-016 div_zero  out  1  one-cycle pulse: divide by zero suppressed.
REQ-017 busy  out  1  FSM is in BUSY.

Function
REQ-018 FSM states: IDLE, BUSY; 6-bit down-counter cnt.
REQ-019 md_a=ex_rs and md_b=ex_rt at all times, combinationally.
REQ-020 Accept condition: IDLE & ex_valid & !ex_flush; md_f=0 in every other cycle.
REQ-021 Accept MULT/MULTU: md_f=3 for exactly the accept cycle; md_sign=1 for MULT, 0 for MULTU; ex_stall=1; next state BUSY with cnt=MUL_LAT-1.
REQ-022 Accept DIV/DIVU with ex_rt!=0: md_f=4; md_sign=1 for DIV, 0 for DIVU; ex_stall=1; next state BUSY with cnt=DIV_LAT-1.
REQ-023 Accept DIV/DIVU with ex_rt==0: md_f=0; HI/LO unchanged; div_zero=1 that cycle; no stall; stay IDLE.
REQ-024 Signed 0x80000000 / 0xFFFFFFFF is issued normally; no special handling.
REQ-025 Accept MTHI: md_f=1. Accept MTLO: md_f=2. No stall; stay IDLE.
REQ-026 MFHI drives mf_result=md_hi; MFLO drives mf_result=md_lo; combinational; no stall; md_f=0.
REQ-027 mf_result=0 for every other op, and whenever ex_valid=0.
REQ-028 BUSY with cnt!=0: ex_stall=1, cnt decrements; inputs ignored; no re-issue.
REQ-029 BUSY with cnt==0: ex_stall=0; next state IDLE; the held instruction retires this cycle.
REQ-030 Total ex_stall high time per mult/div = LAT consecutive cycles, starting in the accept cycle.
REQ-031 LAT=1: accept cycle stalls; the following cycle is BUSY with cnt==0.
REQ-032 ex_flush in the accept cycle: md_f=0; ex_stall=0; stay IDLE.
REQ-033 ex_flush in BUSY: next state IDLE, cnt=0; ex_stall=0 that cycle; HI/LO already written are not reverted.
REQ-034 busy=1 exactly when state==BUSY.

Reset
REQ-035 rst forces state=IDLE, cnt=0 immediately, independent of clk.
REQ-036 While rst=1: md_f=0, ex_stall=0, div_zero=0, busy=0, mf_result=0.
REQ-037 rst mid-BUSY aborts the operation; no md_f pulse is issued after reset releases.

Structure
REQ-038 Package md_pkg contains: md_op_t (4-bit enum: NOP=0, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO); MD_F_* function-code constants; md_state_t.
REQ-039 Single flat module; no sub-module; counter and FSM inline.

Verification
REQ-040 MULT, rs=0xFFFFFFFE, rt=3 -> md_f=3 and md_sign=1 for one cycle; ex_stall high 4 cycles; busy high 4 cycles; MFHI next gives 0xFFFFFFFF, MFLO gives 0xFFFFFFFA.
REQ-041 DIVU, rs=100, rt=7 -> md_f=4 and md_sign=0 once; ex_stall high 32 cycles; then MFLO=14, MFHI=2.
REQ-042 DIV, rt=0 -> md_f=0, div_zero pulses 1 cycle, ex_stall=0, HI/LO unchanged.
REQ-043 MTHI 0x12345678, then MFHI back-to-back -> md_f=1 once, no stall; mf_result=0x12345678.
REQ-044 DIV accepted, ex_flush in 5th stall cycle -> ex_stall drops that cycle, IDLE next cycle; a following MULT is accepted normally.
REQ-045 rst asserted in BUSY cycle 10 of a DIV -> busy and ex_stall drop without waiting for clk; md_f stays 0 after release.
